// File: rtl/uart_bus_bridge_pkg.sv
// rtl/uart_bus_bridge_pkg.sv - shared constants, state encoding and helpers for the UART bus bridge
package uart_bus_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    BUS   = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Bits needed to hold the values 0 .. value-1 (at least one bit).
  function automatic int clogb2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// rtl/byte_timeout.sv - inter-byte silence watchdog for packet reception
module byte_timeout
  import uart_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = clogb2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count idle cycles while a packet is open; any accepted byte or leaving the packet phases restarts it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th silent cycle; a byte arriving that same cycle wins.
  assign expired = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_bus_bridge.sv
// rtl/uart_bus_bridge.sv - byte-stream command parser driving single-cycle peripheral bus transactions
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [ADDR_WIDTH-1:0] o_addr_bus_per,
  output logic                  o_cs_perif,
  output logic                  o_w_r_per,
  inout  wire  [DATA_WIDTH-1:0] io_per_data_bus,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int NDB   = DATA_WIDTH / 8;
  localparam int CNT_W = clogb2(NDB + 1) + 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(NDB - 1);

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [7:0]              addr_hi, addr_hi_n;
  logic [ADDR_WIDTH-1:0]   addr_pend, addr_pend_n;
  logic [DATA_WIDTH-1:0]   wdata, wdata_n;
  logic [DATA_WIDTH-1:0]   rdata, rdata_n;
  logic                    is_rd, is_rd_n;
  logic [7:0]              tx_data_n;
  logic                    tx_valid_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic                    cs_n;
  logic                    w_r_n;
  logic                    drive_q, drive_n;
  logic                    busy_n;
  logic                    err_n;
  logic                    to_clear;
  logic                    to_enable;
  logic                    to_expired;

  assign to_enable = (state == ADDR) || (state == WDATA);

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  // The bridge owns the data bus only during its own write strobe.
  assign io_per_data_bus = drive_q ? wdata : {DATA_WIDTH{1'bz}};

  // State and every output are registered; next values come from the decode below.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      addr_hi        <= '0;
      addr_pend      <= '0;
      wdata          <= '0;
      rdata          <= '0;
      is_rd          <= 1'b0;
      o_tx_data      <= '0;
      o_tx_valid     <= 1'b0;
      o_addr_bus_per <= '0;
      o_cs_perif     <= 1'b0;
      o_w_r_per      <= 1'b0;
      drive_q        <= 1'b0;
      o_busy         <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      addr_hi        <= addr_hi_n;
      addr_pend      <= addr_pend_n;
      wdata          <= wdata_n;
      rdata          <= rdata_n;
      is_rd          <= is_rd_n;
      o_tx_data      <= tx_data_n;
      o_tx_valid     <= tx_valid_n;
      o_addr_bus_per <= addr_n;
      o_cs_perif     <= cs_n;
      o_w_r_per      <= w_r_n;
      drive_q        <= drive_n;
      o_busy         <= busy_n;
      o_err          <= err_n;
    end
  end

  // Packet parsing, bus strobe setup and response sequencing.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    addr_hi_n   = addr_hi;
    addr_pend_n = addr_pend;
    wdata_n     = wdata;
    rdata_n     = rdata;
    is_rd_n     = is_rd;
    tx_data_n   = o_tx_data;
    tx_valid_n  = o_tx_valid;
    addr_n      = o_addr_bus_per;
    cs_n        = 1'b0;
    w_r_n       = o_w_r_per;
    drive_n     = 1'b0;
    err_n       = o_err;
    to_clear    = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_rx_valid) begin
          to_clear = 1'b1;
          cnt_n    = '0;
          if (i_rx_data == CMD_WR) begin
            state_n = ADDR;
            is_rd_n = 1'b0;
          end else if (i_rx_data == CMD_RD) begin
            state_n = ADDR;
            is_rd_n = 1'b1;
          end else begin
            state_n    = RESP;
            is_rd_n    = 1'b0;
            tx_valid_n = 1'b1;
            tx_data_n  = RSP_ERR;
            err_n      = 1'b1;
          end
        end
      end

      ADDR: begin
        if (i_rx_valid) begin
          to_clear = 1'b1;
          if (cnt == ADDR_LAST) begin
            cnt_n = '0;
            if (is_rd) begin
              // Reads have no payload: strobe the bus straight away.
              state_n = BUS;
              addr_n  = ADDR_WIDTH'({addr_hi, i_rx_data});
              cs_n    = 1'b1;
              w_r_n   = 1'b0;
            end else begin
              state_n     = WDATA;
              addr_pend_n = ADDR_WIDTH'({addr_hi, i_rx_data});
            end
          end else begin
            addr_hi_n = i_rx_data;
            cnt_n     = cnt + 1'b1;
          end
        end else if (to_expired) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end

      WDATA: begin
        if (i_rx_valid) begin
          to_clear = 1'b1;
          wdata_n  = (wdata << 8) | DATA_WIDTH'(i_rx_data);
          if (cnt == WORD_LAST) begin
            cnt_n   = '0;
            state_n = BUS;
            addr_n  = addr_pend;
            cs_n    = 1'b1;
            w_r_n   = 1'b1;
            drive_n = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else if (to_expired) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end

      BUS: begin
        // The edge closing the strobe cycle also captures read data.
        state_n    = RESP;
        cnt_n      = '0;
        tx_valid_n = 1'b1;
        if (is_rd) begin
          rdata_n   = io_per_data_bus;
          tx_data_n = io_per_data_bus[DATA_WIDTH-1 -: 8];
        end else begin
          tx_data_n = RSP_ACK;
        end
      end

      RESP: begin
        if (o_tx_valid && i_tx_ready) begin
          tx_valid_n = 1'b0;
          if (!is_rd || (cnt == WORD_LAST)) begin
            state_n = IDLE;
          end else begin
            cnt_n   = cnt + 1'b1;
            rdata_n = rdata << 8;
          end
        end else if (!o_tx_valid) begin
          tx_valid_n = 1'b1;
          tx_data_n  = rdata[DATA_WIDTH-1 -: 8];
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
